// File: rtl/unbuffer_sched_pkg.sv
// Shared widths and read-FSM encoding for the unbuffer scheduler.
package unbuffer_sched_pkg;
  localparam int NIB_W         = 4;
  localparam int NIBS_PER_WORD = 6;
  localparam int WORD_W        = NIB_W * NIBS_PER_WORD;
  localparam int PH_W          = 3;

  // IDLE wait for group | SHIFT replay 6 nibbles | FLUSH unbuffer loads | CAPT output register
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CAPT  = 2'd3
  } rd_state_e;
endpackage

// File: rtl/unbuffer_sched_fifo.sv
// Whole-group nibble FIFO: {sof,nib} entries, partial-group rollback, committed-group count.
module unbuffer_sched_fifo
  import unbuffer_sched_pkg::*;
#(
  parameter int FIFO_GROUPS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic             wr_sof_i,
  input  logic [NIB_W-1:0] wr_nib_i,
  input  logic             pop_i,
  input  logic             take_i,
  output logic [NIB_W-1:0] head_nib_o,
  output logic             head_sof_o,
  output logic             full_o,
  output logic             grp_avail_o,
  output logic             rollback_o
);
  localparam int DEPTH = NIBS_PER_WORD * FIFO_GROUPS;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int GW    = $clog2(FIFO_GROUPS + 1);

  logic [NIB_W:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, base_q, base_d, wr_addr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [PH_W-1:0] wpos_q, wpos_d;
  logic            rollback, commit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rollback = wr_en_i && wr_sof_i && (wpos_q != '0);
    commit   = wr_en_i && !rollback && (wpos_q == PH_W'(NIBS_PER_WORD - 1));
    wr_addr  = rollback ? base_q : wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    base_d   = base_q;
    wpos_d   = wpos_q;
    cnt_d    = cnt_q;
    rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (wr_en_i) begin
      wr_ptr_d = ptr_inc(wr_addr);
      if (commit) begin
        wpos_d = '0;
        base_d = ptr_inc(wr_ptr_q);
      end else if (rollback) begin
        wpos_d = PH_W'(1);
      end else begin
        wpos_d = wpos_q + PH_W'(1);
      end
      // the partial group's entries are released and the sof nibble replaces them
      cnt_d = rollback ? cnt_q - CW'(wpos_q) + CW'(1) : cnt_q + CW'(1);
    end
    if (pop_i) cnt_d = cnt_d - CW'(1);
    grp_d = grp_q + GW'(commit) - GW'(take_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      grp_q    <= '0;
      wpos_q   <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_addr] <= {wr_sof_i, wr_nib_i};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      grp_q    <= grp_d;
      wpos_q   <= wpos_d;
    end
  end

  assign head_nib_o  = mem_q[rd_ptr_q][NIB_W-1:0];
  assign head_sof_o  = mem_q[rd_ptr_q][NIB_W];
  assign full_o      = (cnt_q == CW'(DEPTH));
  assign grp_avail_o = (grp_q != '0);
  assign rollback_o  = rollback;
endmodule

// File: rtl/unbuffer_sched.sv
// Replays aligned 6-nibble groups into the unbuffer and captures its words into a valid/ready register.
module unbuffer_sched
  import unbuffer_sched_pkg::*;
#(
  parameter int FIFO_GROUPS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIB_W-1:0]  in_nib,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NIB_W-1:0]  ub_nib,
  output logic              ub_enable,
  output logic              ub_reset,
  input  logic [WORD_W-1:0] ub_word,
  output logic [WORD_W-1:0] word_out,
  output logic              word_sof,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              locked,
  output logic              align_err
);
  rd_state_e         state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              sof_lat_q, sof_lat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wsof_q, wsof_d, wvalid_q, wvalid_d;
  logic              locked_q, aerr_q, ub_rst_q;
  logic              accept, wr_en, pop, take, full, grp_avail, rollback, head_sof;
  logic [NIB_W-1:0]  head_nib;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  // before lock only a frame start may enter the FIFO
  assign wr_en    = accept && (locked_q || in_sof);

  unbuffer_sched_fifo #(.FIFO_GROUPS(FIFO_GROUPS)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_sof_i   (in_sof),
    .wr_nib_i   (in_nib),
    .pop_i      (pop),
    .take_i     (take),
    .head_nib_o (head_nib),
    .head_sof_o (head_sof),
    .full_o     (full),
    .grp_avail_o(grp_avail),
    .rollback_o (rollback)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    sof_lat_d = sof_lat_q;
    word_d    = word_q;
    wsof_d    = wsof_q;
    wvalid_d  = wvalid_q && !word_ready;
    pop       = 1'b0;
    take      = 1'b0;
    ub_enable = 1'b0;
    ub_nib    = '0;
    case (state_q)
      ST_IDLE: begin
        if (grp_avail) begin
          state_d = ST_SHIFT;
          ph_d    = '0;
          take    = 1'b1;
        end
      end
      ST_SHIFT: begin
        pop    = 1'b1;
        ub_nib = head_nib;
        if (ph_q == '0) begin
          ub_enable = 1'b1;
          sof_lat_d = head_sof;
        end
        if (ph_q == PH_W'(NIBS_PER_WORD - 1)) state_d = ST_FLUSH;
        else ph_d = ph_q + PH_W'(1);
      end
      ST_FLUSH: state_d = ST_CAPT;
      ST_CAPT: begin
        if (!wvalid_q || word_ready) begin
          word_d   = ub_word;
          wsof_d   = sof_lat_q;
          wvalid_d = 1'b1;
          if (grp_avail) begin
            state_d = ST_SHIFT;
            ph_d    = '0;
            take    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      sof_lat_q <= 1'b0;
      word_q    <= '0;
      wsof_q    <= 1'b0;
      wvalid_q  <= 1'b0;
      locked_q  <= 1'b0;
      aerr_q    <= 1'b0;
      ub_rst_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      sof_lat_q <= sof_lat_d;
      word_q    <= word_d;
      wsof_q    <= wsof_d;
      wvalid_q  <= wvalid_d;
      locked_q  <= locked_q | (accept && in_sof);
      aerr_q    <= rollback;
      ub_rst_q  <= 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_sof   = wsof_q;
  assign word_valid = wvalid_q;
  assign locked     = locked_q;
  assign align_err  = aerr_q;
  assign ub_reset   = ub_rst_q;
endmodule

// File: tb/tb_unbuffer_sched.sv
// Scoreboard bench for unbuffer_sched with a behavioural unbuffer model on ub_*.
module tb_unbuffer_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_nib;
  logic        in_sof, in_valid, in_ready;
  logic [3:0]  ub_nib;
  logic        ub_enable, ub_reset;
  logic [23:0] ub_word;
  logic [23:0] word_out;
  logic        word_sof, word_valid, word_ready, locked, align_err;

  unbuffer_sched #(.FIFO_GROUPS(2)) dut (
    .clk(clk), .reset(reset), .in_nib(in_nib), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .ub_nib(ub_nib), .ub_enable(ub_enable), .ub_reset(ub_reset),
    .ub_word(ub_word), .word_out(word_out), .word_sof(word_sof), .word_valid(word_valid),
    .word_ready(word_ready), .locked(locked), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // unbuffer: shifts one nibble per cycle, loads its output the cycle after the sixth nibble
  logic [23:0] ub_sh, ub_out;
  logic [2:0]  ub_cnt;
  assign ub_word = ub_out;
  always @(posedge clk) begin
    if (ub_reset) begin
      ub_sh <= '0; ub_out <= '0; ub_cnt <= '0;
    end else begin
      ub_sh <= {ub_sh[19:0], ub_nib};
      if (ub_enable) ub_cnt <= 3'd1;
      else if (ub_cnt == 3'd6) begin ub_out <= ub_sh; ub_cnt <= 3'd0; end
      else if (ub_cnt != 3'd0) ub_cnt <= ub_cnt + 3'd1;
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [24:0] exp_word_q[$];
  logic [23:0] exp_nib_q[$];
  int en_q[$];
  int en_cnt = 0, aerr_cnt = 0;
  bit check_lat = 0, check_gap = 0, gap_armed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // monitor: nibble stream into the unbuffer and words leaving the output register
  initial begin
    bit collecting = 0, prev_wv = 0;
    int idx = 0, en_prev = 0;
    logic [23:0] acc = '0;
    logic [24:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        collecting = 0;
        prev_wv = 0;
      end else begin
        if (ub_enable) begin
          if (collecting) fail("ub_enable_mid_group");
          collecting = 1; idx = 0; acc = '0;
          en_q.push_back(cyc);
          en_cnt++;
          if (check_gap) begin
            if (gap_armed) chk("enable_gap", cyc - en_prev, 8);
            gap_armed = 1;
          end
          en_prev = cyc;
        end
        if (collecting) begin
          acc = {acc[19:0], ub_nib};
          idx++;
          if (idx == 6) begin
            collecting = 0;
            if (exp_nib_q.size() == 0) fail("ub_nib_unexpected_group");
            else chk("ub_nib_stream", acc, exp_nib_q.pop_front());
          end
        end
        if (word_valid && !prev_wv && en_q.size() > 0) begin
          int c0;
          c0 = en_q.pop_front();
          if (check_lat) chk("latency", cyc - c0, 8);
        end
        if (word_valid && word_ready) begin
          if (exp_word_q.size() == 0) fail("word_unexpected");
          else begin
            e = exp_word_q.pop_front();
            chk("word_out", word_out, e[23:0]);
            chk("word_sof", word_sof, e[24]);
          end
        end
        prev_wv = word_valid;
        if (align_err) aerr_cnt++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic s, input logic [3:0] n);
    int g;
    g = 0;
    in_valid = 1'b1; in_sof = s; in_nib = n;
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (!in_ready) fail("in_ready_timeout");
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_group(input logic s, input logic [23:0] w, input bit expect_out);
    if (expect_out) begin
      exp_word_q.push_back({s, w});
      exp_nib_q.push_back(w);
    end
    for (int i = 0; i < 6; i++) send((i == 0) ? s : 1'b0, w[23-4*i -: 4]);
  endtask

  initial begin
    int e0, a0, g;
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_nib = '0; word_ready = 1'b1;
    // reset values
    @(negedge clk);
    chk("rst_ub_reset", ub_reset, 1); chk("rst_word_valid", word_valid, 0);
    chk("rst_word_out", word_out, 0); chk("rst_locked", locked, 0);
    chk("rst_in_ready", in_ready, 1); chk("rst_align_err", align_err, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ub_reset_held_at_release", ub_reset, 1);
    @(negedge clk);
    chk("ub_reset_cleared", ub_reset, 0);

    // unlocked nibbles are dropped, then first sof locks
    for (int i = 0; i < 7; i++) send(1'b0, 4'(i + 3));
    wait_cycles(12);
    chk("unlocked_locked", locked, 0);
    chk("unlocked_no_enable", en_cnt, 0);
    check_lat = 1;
    send_group(1'b1, 24'hC0FFEE, 1);
    chk("lock_after_sof", locked, 1);
    wait_cycles(20);

    // single group, latency 8
    en_q.delete();
    send_group(1'b1, 24'hABCDEF, 1);
    wait_cycles(20);

    // two back-to-back groups, enables 8 cycles apart
    en_q.delete();
    gap_armed = 0; check_gap = 1;
    send_group(1'b1, 24'h123456, 1);
    send_group(1'b0, 24'h789ABC, 1);
    wait_cycles(25);
    check_gap = 0;

    // partial group discarded on resync
    en_q.delete();
    a0 = aerr_cnt;
    send(1'b1, 4'h1); send(1'b0, 4'h2); send(1'b0, 4'h3);
    send_group(1'b1, 24'hABCDEF, 1);
    wait_cycles(20);
    chk("align_err_pulses", aerr_cnt - a0, 1);

    // output stall with four groups queued
    check_lat = 0;
    word_ready = 1'b0;
    e0 = en_cnt;
    send_group(1'b1, 24'h13579B, 1);
    send_group(1'b0, 24'h2468AC, 1);
    send_group(1'b0, 24'hFEDCBA, 1);
    send_group(1'b0, 24'h0F1E2D, 1);
    wait_cycles(20);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_word_valid", word_valid, 1);
    chk("stall_word_out", word_out, 24'h13579B);
    chk("stall_enables", en_cnt - e0, 2);
    wait_cycles(10);
    chk("stall_word_held", word_out, 24'h13579B);
    chk("stall_no_enable", en_cnt - e0, 2);
    word_ready = 1'b1;
    wait_cycles(60);
    chk("stall_drained", exp_word_q.size(), 0);

    // async reset in the middle of a group replay
    en_q.delete();
    send_group(1'b1, 24'h777777, 0);
    g = 0;
    while (!ub_enable && g < 50) begin @(negedge clk); g++; end
    if (!ub_enable) fail("mid_reset_enable_timeout");
    wait_cycles(2);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ub_reset", ub_reset, 1); chk("midrst_word_valid", word_valid, 0);
    chk("midrst_locked", locked, 0); chk("midrst_in_ready", in_ready, 1);
    exp_word_q.delete(); exp_nib_q.delete(); en_q.delete();
    wait_cycles(2);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ub_reset_cleared", ub_reset, 0);
    check_lat = 1;
    send_group(1'b1, 24'h13C0DE, 1);
    wait_cycles(20);
    chk("final_words_drained", exp_word_q.size(), 0);
    chk("final_nibs_drained", exp_nib_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
